// File: rtl/fetch_pkg.sv
// fetch_pkg: state encoding, reset/step defaults and the bubble word shared by
// the instruction-fetch stage. Optional feature macro: IF_MISALIGN_TRAP_EN.
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif

package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;
    localparam logic [31:0] BUBBLE           = '0;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } fetch_state_t;

endpackage

// File: rtl/if_pc_gen.sv
// if_pc_gen: program counter with reset, sequential increment and redirect.
// Redirect targets are word-aligned by clearing the low two bits.
// With IF_MISALIGN_TRAP_EN defined it also reports a misaligned target.
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif

module if_pc_gen
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = `ADDRESS_LEN,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(PC_STEP_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_inc
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic              misaligned
`endif
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(3);

    // Sequential successor wraps silently modulo 2^ADDR_W
    assign pc_inc = pc + PC_STEP;

`ifdef IF_MISALIGN_TRAP_EN
    assign misaligned = |target[1:0];
`endif

    // PC register: redirect has priority over the sequential advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= target & ~ALIGN_MASK;
        end else if (advance) begin
            pc <= pc_inc;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch with one outstanding memory request,
// branch redirect with stale-response discard, and hazard freeze.
// Optional feature macro: IF_MISALIGN_TRAP_EN (misaligned redirect traps to S_HALT).
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif

module if_fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = `ADDRESS_LEN,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(PC_STEP_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic              imem_rvalid,
    input  logic [ADDR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] instruction_out,
    output logic              fetch_stall,
    output logic              flush_out
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic              misalign_err
`endif
);

    fetch_state_t      state, state_nx;
    logic              discard, discard_nx;
    logic              br_event;
    logic              bad_target;
    logic              capture;
    logic              redirect;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;

    if_pc_gen #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_gen (
        .clk      (clk),
        .rst      (rst),
        .advance  (capture),
        .redirect (redirect),
        .target   (br_addr),
        .pc       (pc),
        .pc_inc   (pc_inc)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .misaligned (bad_target)
`endif
    );

`ifndef IF_MISALIGN_TRAP_EN
    assign bad_target = 1'b0;
`endif

    // Request is gated by reset so nothing is issued while reset is held
    assign imem_req  = rst && (state == S_REQ);
    assign imem_addr = pc;

    // State and discard flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_REQ;
            discard <= 1'b0;
        end else begin
            state   <= state_nx;
            discard <= discard_nx;
        end
    end

    // Next state: redirect beats rvalid, rvalid beats freeze; S_HALT ignores redirects
    always_comb begin
        state_nx   = state;
        discard_nx = discard;
        capture    = 1'b0;
        redirect   = 1'b0;
        br_event   = br_taken && (state != S_HALT);
        if (br_event && bad_target) begin
            state_nx   = S_HALT;
            discard_nx = 1'b0;
        end else if (br_event) begin
            redirect = 1'b1;
            case (state)
                S_REQ: begin
                    if (imem_ack) begin
                        state_nx   = S_WAIT;
                        discard_nx = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_nx   = S_REQ;
                        discard_nx = 1'b0;
                    end else begin
                        discard_nx = 1'b1;
                    end
                end
                S_HOLD:  state_nx = S_REQ;
                default: state_nx = state;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ack) state_nx = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (discard) begin
                            discard_nx = 1'b0;
                            state_nx   = S_REQ;
                        end else begin
                            capture  = 1'b1;
                            state_nx = freeze ? S_HOLD : S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!freeze) state_nx = S_REQ;
                end
                S_HALT:  state_nx = S_HALT;
                default: state_nx = state;
            endcase
        end
    end

    // Output registers: flush inserts a bubble, capture presents the new word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_out          <= '0;
            instruction_out <= ADDR_W'(BUBBLE);
            fetch_stall     <= 1'b1;
            flush_out       <= 1'b0;
        end else begin
            flush_out <= br_event;
            if (br_event) begin
                instruction_out <= ADDR_W'(BUBBLE);
                fetch_stall     <= 1'b1;
            end else if (capture) begin
                instruction_out <= imem_rdata;
                pc_out          <= pc_inc;
                fetch_stall     <= 1'b0;
            end else begin
                fetch_stall <= 1'b1;
            end
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    // Sticky misalignment flag, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_err <= 1'b0;
        end else if (br_event && bad_target) begin
            misalign_err <= 1'b1;
        end
    end
`endif

endmodule
